// File: rtl/verbus_arbiter_if.sv
// One Verbus link: a requester drives valid/address/wstrobe/wdata,
// and the responder returns rdata/ready/irq.
interface verbus_arbiter_if;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport master (output valid, address, wstrobe, wdata, input rdata, ready, irq);
    modport slave  (input valid, address, wstrobe, wdata, output rdata, ready, irq);
endinterface

// File: rtl/verbus_arbiter.sv
// Two-requester Verbus arbiter (m0 = data bus, m1 = instruction bus) with
// alternating fairness and a per-transaction response watchdog.
module verbus_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             reset,
    verbus_arbiter_if.slave  m0,
    verbus_arbiter_if.slave  m1,
    verbus_arbiter_if.master s,
    output logic             bus_error,
    output logic [31:0]      error_address,
    input  logic             error_clear
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 0 = m0, 1 = m1
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic        busy, own_valid, oth_valid, expire, done;
    logic [31:0] rsp;
    logic        unused_m1_wstrobe;

    // m1 is read-only; its strobes are never forwarded.
    assign unused_m1_wstrobe = ^{m1.wstrobe, m1.wdata};

    assign busy      = (state_q == BUSY);
    assign own_valid = owner_q ? m1.valid : m0.valid;
    assign oth_valid = owner_q ? m0.valid : m1.valid;
    // A same-cycle s_ready beats the watchdog.
    assign expire    = (TIMEOUT > 0) && busy && own_valid && !s.ready && (cnt_q == CNT_LAST);
    assign done      = busy && own_valid && (s.ready || expire);
    assign rsp       = expire ? ERR_RDATA : s.rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (error_clear) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        // A new error overrides a simultaneous clear and records its address.
        if (expire) begin
            err_d = 1'b1;
            if (!err_q || error_clear) err_addr_d = s.address;
        end

        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    owner_d = (m0.valid && m1.valid) ? ~last_q : m1.valid;
                end
            end
            BUSY: begin
                if (!own_valid) begin
                    // Owner abandoned its request: drop it silently.
                    state_d = IDLE;
                end else if (done) begin
                    last_d = owner_q;
                    cnt_d  = '0;
                    if (oth_valid) owner_d = ~owner_q;
                    else           state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s.valid   = busy && own_valid;
    assign s.address = !busy ? 32'h0 : (owner_q ? m1.address : m0.address);
    assign s.wstrobe = (busy && !owner_q) ? m0.wstrobe : 4'h0;
    assign s.wdata   = (busy && !owner_q) ? m0.wdata   : 32'h0;

    assign m0.ready = done && !owner_q;
    assign m1.ready = done &&  owner_q;
    assign m0.rdata = (busy && !owner_q) ? rsp : 32'h0;
    assign m1.rdata = (busy &&  owner_q) ? rsp : 32'h0;
    assign m0.irq   = s.irq;
    assign m1.irq   = s.irq;

    assign bus_error     = err_q;
    assign error_address = err_addr_q;
endmodule

// File: doc/verbus_arbiter.md
Name: verbus_arbiter

Overview:
- Shares a single Verbus target port (memory/peripheral fabric) between two Verbus requesters: m0 = CPU data bus (read/write), m1 = CPU instruction bus (read-only).
- Sits between Vermicel's ibus/dbus and a single-ported memory.
- Registered grant FSM with alternating fairness and a per-transaction response watchdog.
- The watchdog reports a sticky bus error.

Parameters:
- TIMEOUT, 16: target cycles allowed before a transaction is force-completed. 0 disables the watchdog. Counter width is $clog2(TIMEOUT+1).
- ERR_RDATA, 32'hDEADBEEF: rdata returned to the owner on a forced completion.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m0_valid / m1_valid  in  1  request valid. Held high, with fields stable, until the cycle the matching mX_ready=1.
- m0_address / m1_address  in  32  byte address.
- m0_wstrobe  in  4  byte write enables. 0000 means read.
- m0_wdata  in  32  write data.
- m0_rdata / m1_rdata  out  32  read data, valid when mX_ready=1.
- m0_ready / m1_ready  out  1  transaction complete.
- m0_irq / m1_irq  out  1  copy of s_irq.
- s_valid  out  1  request to target.
- s_address  out  32  forwarded address.
- s_wstrobe  out  4  forwarded strobes. m1 always forwards 0000.
- s_wdata  out  32  forwarded write data.
- s_rdata  in  32  target read data.
- s_ready  in  1  target completion.
- s_irq  in  1  interrupt from target side.
- bus_error  out  1  sticky: a watchdog completion occurred.
- error_address  out  32  address of the first timed-out transaction.
- error_clear  in  1  synchronous clear of bus_error and error_address.

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=m0, last=m1, count=0, bus_error=0, error_address=0.
  - All mX_ready=0 and s_valid=0.
  - s_address, s_wstrobe, s_wdata and mX_rdata are 0 while not granted.
- States:
  - IDLE: nothing forwarded; s_valid=0.
  - BUSY: owner's valid/address/wstrobe/wdata drive s_*. s_valid is the owner's valid.
- IDLE -> BUSY:
  - If exactly one mX_valid=1, that requester becomes owner.
  - If both are valid, the requester that is not `last` wins. After reset this is m0.
  - Grant is registered: first s_valid is the cycle after the request is seen in IDLE (1-cycle arbitration latency).
- Completion in BUSY: s_ready=1, or a watchdog expiry.
  - Owner's mX_ready=1 for exactly that cycle. The non-owner's ready is always 0.
  - Owner's rdata = s_rdata, or ERR_RDATA on watchdog expiry.
  - last <= owner.
- After completion:
  - If the other requester's valid=1 in the completion cycle: next state BUSY, owner = other. No idle bubble.
  - Otherwise: next state IDLE.
  - The completing owner is never re-granted directly, because its valid is still high in that cycle.
- Watchdog (TIMEOUT>0):
  - count clears on entry to BUSY and increments each BUSY cycle with s_ready=0.
  - When count==TIMEOUT-1 and s_ready=0: forced completion.
  - On a forced completion, bus_error<=1. error_address<=s_address only if bus_error was 0.
  - s_ready in the same cycle as expiry counts as normal completion, with no error.
- error_clear=1: clears bus_error and error_address next edge. A simultaneous new error wins (sets).
- Owner dropping valid in BUSY before ready is a protocol violation.
  - Arbiter returns to IDLE next cycle with no ready and no error.
- s_irq passes combinationally to m0_irq and m1_irq in every state.
- reset asserted mid-transaction: immediate return to reset values. The target sees s_valid fall asynchronously.

Test Plan:
- Single m0 write:
  - Stimulus: m0_valid=1, address 0000A100, wstrobe 1111, wdata 00000096; s_ready=1 on the 2nd BUSY cycle.
  - Response: s_valid rises 1 cycle after m0_valid. s_* equals the m0 fields. m0_ready pulses one cycle in step with s_ready. m1_ready stays 0.
- Both requesters valid simultaneously from IDLE after reset:
  - Stimulus: m0 read A100, m1 read 00000004, s_ready=1 immediately.
  - Response: m0 is served first. m1 is granted in the very next cycle with no IDLE between. m1_rdata equals s_rdata (e.g. 8C15F3E4).
- Alternation:
  - Stimulus: both requesters re-request continuously for 6 transactions.
  - Response: owners go m0, m1, m0, m1, m0, m1. s_wstrobe is 0000 on every m1 transaction, even if m1 is driven nonzero internally.
- Watchdog with TIMEOUT=4:
  - Stimulus: m1 reads 00000040, s_ready held 0.
  - Response: m1_ready=1 on the 4th BUSY cycle with m1_rdata=DEADBEEF. bus_error=1, error_address=00000040.
  - A second timeout at 00000080 leaves error_address at 00000040.
  - error_clear then zeroes both.
- Expiry tie:
  - Stimulus: s_ready=1 exactly on the 4th BUSY cycle.
  - Response: normal completion, rdata=s_rdata, bus_error stays 0.
- Reset mid-BUSY:
  - Stimulus: assert reset=0 between edges during a pending m0 store.
  - Response: s_valid and m0_ready go 0 at once. After release, the FSM is in IDLE and m0 has priority on a tie.
- irq: toggling s_irq is reflected on both mX_irq in IDLE and BUSY.
